// File: rtl/ram_bus_ctrl.sv
// Single-master bus controller for the 16-bit RAM. It turns a one-cycle CPU request into a
// chip-select handshake, captures read data, and aborts out-of-range or stalled transfers.
module ram_bus_ctrl #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDR_WIDTH    = 16,
  parameter int RAM_ADDR_BITS = 14,
  parameter int TIMEOUT       = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  cs_ram,
  output logic                  read,
  output logic [ADDR_WIDTH-1:0] address,
  inout  wire  [DATA_WIDTH-1:0] data,
  input  logic                  ready_ram
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(1) << RAM_ADDR_BITS;
  localparam logic [CNT_W-1:0]    CNT_LIMIT  = CNT_W'(TIMEOUT);

  // state | meaning
  // IDLE  | waiting for a CPU request
  // REQ   | cs asserted, waiting for the RAM to pull ready low
  // WAIT  | RAM busy, waiting for ready to return high
  // DONE  | one-cycle completion pulse, cs released
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t                state_q, state_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0] address_q, address_d;
  logic                  cs_q, cs_d;
  logic                  read_q, read_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      cnt_inc;

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    address_d = address_q;
    cs_d      = cs_q;
    read_d    = read_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = we;
          wdata_d = wdata;
          if ({1'b0, addr} >= ADDR_LIMIT) begin
            state_d = DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d   = REQ;
            cs_d      = 1'b1;
            read_d    = ~we;
            address_d = addr;
            cnt_d     = '0;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_inc;
        if (cnt_inc == CNT_LIMIT) begin
          state_d = DONE;
          cs_d    = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else if (!ready_ram) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_inc;
        // A completion seen on the same edge as the timeout is honoured.
        if (ready_ram) begin
          state_d = DONE;
          cs_d    = 1'b0;
          done_d  = 1'b1;
          if (!we_q) rdata_d = data;
        end else if (cnt_inc == CNT_LIMIT) begin
          state_d = DONE;
          cs_d    = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        read_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      address_q <= '0;
      cs_q      <= 1'b0;
      read_q    <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      address_q <= address_d;
      cs_q      <= cs_d;
      read_q    <= read_d;
      done_q    <= done_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
    end
  end

  // Drive the bus only for an active write so the RAM owns it during reads.
  assign data    = (cs_q & ~read_q) ? wdata_q : 'z;
  assign rdata   = rdata_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign cs_ram  = cs_q;
  assign read    = read_q;
  assign address = address_q;

endmodule

// File: tb/tb_ram_bus_ctrl.sv
// Self-checking bench for ram_bus_ctrl with a behavioural RAM model and an expected-result queue.
module tb_ram_bus_ctrl;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] wdata = '0;
  logic [15:0] rdata;
  logic        busy, done, err, cs_ram, read;
  logic [15:0] address;
  wire  [15:0] data_bus;
  logic        ready_ram;
  logic        ram_stuck = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        e;
    logic        chk_rd;
    logic [15:0] rd;
    int          lat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  ram_bus_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .RAM_ADDR_BITS(14), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .busy(busy), .done(done), .err(err), .cs_ram(cs_ram),
    .read(read), .address(address), .data(data_bus), .ready_ram(ready_ram)
  );

  // RAM model: pulls ready low the cycle after it sees cs, completes one cycle later.
  logic [15:0] mem [0:16383];
  logic [1:0]  ph;
  assign data_bus = (cs_ram && read) ? mem[address[13:0]] : 'z;

  always @(posedge clk) begin
    if (rst || !cs_ram) begin
      ph        <= 2'd0;
      ready_ram <= 1'b1;
    end else if (ram_stuck) begin
      ready_ram <= 1'b1;
    end else begin
      case (ph)
        2'd0: begin ready_ram <= 1'b0; ph <= 2'd1; end
        2'd1: begin
          ready_ram <= 1'b1;
          ph        <= 2'd2;
          if (!read) mem[address[13:0]] <= data_bus;
        end
        default: ready_ram <= 1'b1;
      endcase
    end
  end

  task automatic run_xfer(input logic w, input logic [15:0] a, input logic [15:0] wd,
                          input int inject_at, output int lat, output int cs_cyc,
                          output logic e, output logic [15:0] rd, output logic cs_at_done,
                          output int bus_bad, output logic got);
    lat = 0; cs_cyc = 0; bus_bad = 0; got = 1'b0; e = 1'bx; rd = 'x; cs_at_done = 1'bx;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = wd;
    @(posedge clk);
    #1 req = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (inject_at == lat) begin
        req = 1'b1; we = 1'b1; addr = 16'h0020; wdata = 16'hDEAD;
      end else begin
        req = 1'b0;
      end
      if (cs_ram) cs_cyc++;
      if (cs_ram && !read && data_bus !== wd) bus_bad++;
      if (cs_ram && address !== a) bus_bad++;
      if (done) begin
        got = 1'b1; e = err; rd = rdata; cs_at_done = cs_ram;
      end
    end
    req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({cs_ram, read, busy, done, err} !== 5'b01000) begin
      errors++;
      $display("FAIL reset_ctrl: cs/read/busy/done/err=%b required 01000", {cs_ram, read, busy, done, err});
    end
    checks++;
    if (rdata !== 16'h0 || address !== 16'h0) begin
      errors++;
      $display("FAIL reset_data: rdata=%h address=%h required 0000 0000", rdata, address);
    end
    rst = 1'b0;
  endtask

  // Pops one expectation and compares the observed transfer against it.
  task automatic do_and_check(input string nm, input logic w, input logic [15:0] a,
                              input logic [15:0] wd, input int inject_at, output int cs_cyc);
    int lat, bus_bad;
    logic e, cs_d, got;
    logic [15:0] rd;
    exp_t ex;
    run_xfer(w, a, wd, inject_at, lat, cs_cyc, e, rd, cs_d, bus_bad, got);
    ex = sb.pop_front();
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_done: no done within 40 cycles, required latency %0d", nm, ex.lat);
    end else begin
      checks++;
      if (lat != ex.lat) begin
        errors++;
        $display("FAIL %s_latency: got %0d required %0d", nm, lat, ex.lat);
      end
      checks++;
      if (e !== ex.e) begin
        errors++;
        $display("FAIL %s_err: got %b required %b", nm, e, ex.e);
      end
      if (ex.chk_rd) begin
        checks++;
        if (rd !== ex.rd) begin
          errors++;
          $display("FAIL %s_rdata: got %h required %h", nm, rd, ex.rd);
        end
      end
      checks++;
      if (cs_d !== 1'b0) begin
        errors++;
        $display("FAIL %s_cs_gap: cs_ram=%b during done, required 0", nm, cs_d);
      end
      checks++;
      if (bus_bad != 0) begin
        errors++;
        $display("FAIL %s_bus: %0d bad address/data samples, required 0", nm, bus_bad);
      end
    end
  endtask

  task automatic test_write_read();
    int cs_cyc;
    sb.push_back('{1'b0, 1'b0, 16'h0, 4});
    do_and_check("wr", 1'b1, 16'h0010, 16'hA5C3, 0, cs_cyc);
    sb.push_back('{1'b0, 1'b1, 16'hA5C3, 4});
    do_and_check("rd", 1'b0, 16'h0010, 16'h0, 0, cs_cyc);
    checks++;
    if (cs_cyc != 3) begin
      errors++;
      $display("FAIL rd_cs_cycles: got %0d required 3", cs_cyc);
    end
  endtask

  task automatic test_out_of_range();
    int cs_cyc;
    sb.push_back('{1'b1, 1'b1, 16'hA5C3, 1});
    do_and_check("oor", 1'b0, 16'h4000, 16'h0, 0, cs_cyc);
    checks++;
    if (cs_cyc != 0) begin
      errors++;
      $display("FAIL oor_cs: cs_ram high %0d cycles, required 0", cs_cyc);
    end
  endtask

  task automatic test_timeout();
    int cs_cyc;
    ram_stuck = 1'b1;
    sb.push_back('{1'b1, 1'b1, 16'hA5C3, TIMEOUT + 1});
    do_and_check("tmo", 1'b0, 16'h0100, 16'h0, 0, cs_cyc);
    checks++;
    if (cs_cyc != TIMEOUT) begin
      errors++;
      $display("FAIL tmo_cs_cycles: got %0d required %0d", cs_cyc, TIMEOUT);
    end
    ram_stuck = 1'b0;
    sb.push_back('{1'b0, 1'b1, 16'hA5C3, 4});
    do_and_check("tmo_after", 1'b0, 16'h0010, 16'h0, 0, cs_cyc);
  endtask

  task automatic test_busy_ignore();
    int cs_cyc, extra;
    sb.push_back('{1'b0, 1'b0, 16'h0, 4});
    do_and_check("bi_pre", 1'b1, 16'h0020, 16'h1234, 0, cs_cyc);
    sb.push_back('{1'b0, 1'b0, 16'h0, 4});
    do_and_check("bi_main", 1'b1, 16'h0030, 16'h5555, 2, cs_cyc);
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || cs_ram) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL bi_extra: %0d cycles with done/cs after first transfer, required 0", extra);
    end
    sb.push_back('{1'b0, 1'b1, 16'h1234, 4});
    do_and_check("bi_rd20", 1'b0, 16'h0020, 16'h0, 0, cs_cyc);
    sb.push_back('{1'b0, 1'b1, 16'h5555, 4});
    do_and_check("bi_rd30", 1'b0, 16'h0030, 16'h0, 0, cs_cyc);
  endtask

  task automatic test_reset_mid_op();
    int cs_cyc;
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 16'h0010;
    @(posedge clk);
    #1 req = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (cs_ram !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_inflight: cs=%b busy=%b required 1 1", cs_ram, busy);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({cs_ram, read, busy, done, err} !== 5'b01000 || rdata !== 16'h0) begin
      errors++;
      $display("FAIL mid_reset: cs/read/busy/done/err=%b rdata=%h required 01000 0000",
               {cs_ram, read, busy, done, err}, rdata);
    end
    sb.push_back('{1'b0, 1'b1, 16'hA5C3, 4});
    do_and_check("mid_rd", 1'b0, 16'h0010, 16'h0, 0, cs_cyc);
  endtask

  task automatic test_back_to_back();
    int cs_cyc;
    for (int i = 0; i < 8; i++) begin
      sb.push_back('{1'b0, 1'b0, 16'h0, 4});
      do_and_check("b2b_wr", 1'b1, 16'(i), 16'(i) ^ 16'hFFFF, 0, cs_cyc);
    end
    for (int i = 0; i < 8; i++) begin
      sb.push_back('{1'b0, 1'b1, 16'(i) ^ 16'hFFFF, 4});
      do_and_check("b2b_rd", 1'b0, 16'(i), 16'h0, 0, cs_cyc);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_out_of_range();
    test_timeout();
    test_busy_ignore();
    test_reset_mid_op();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
